// File: rtl/axi_riscv_excl_mem_resp.sv
// AXI4 responder with a register-file memory and a single-entry exclusive monitor.
// One write and one read burst in flight; legality is decided once per burst at the address handshake.
module axi_riscv_excl_mem_resp #(
  parameter logic [63:0] ADDR_BASE      = 64'h0,
  parameter int unsigned MEM_WORDS      = 256,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] slv_aw_addr_i,
  input  logic [7:0]                slv_aw_len_i,
  input  logic [2:0]                slv_aw_size_i,
  input  logic [1:0]                slv_aw_burst_i,
  input  logic                      slv_aw_lock_i,
  input  logic [5:0]                slv_aw_atop_i,
  input  logic [AXI_ID_WIDTH-1:0]   slv_aw_id_i,
  input  logic                      slv_aw_valid_i,
  output logic                      slv_aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] slv_w_data_i,
  input  logic [AXI_STRB_WIDTH-1:0] slv_w_strb_i,
  input  logic                      slv_w_last_i,
  input  logic                      slv_w_valid_i,
  output logic                      slv_w_ready_o,
  output logic [1:0]                slv_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   slv_b_id_o,
  output logic                      slv_b_valid_o,
  input  logic                      slv_b_ready_i,
  input  logic [AXI_ADDR_WIDTH-1:0] slv_ar_addr_i,
  input  logic [7:0]                slv_ar_len_i,
  input  logic [2:0]                slv_ar_size_i,
  input  logic [1:0]                slv_ar_burst_i,
  input  logic                      slv_ar_lock_i,
  input  logic [AXI_ID_WIDTH-1:0]   slv_ar_id_i,
  input  logic                      slv_ar_valid_i,
  output logic                      slv_ar_ready_o,
  output logic [AXI_DATA_WIDTH-1:0] slv_r_data_o,
  output logic [1:0]                slv_r_resp_o,
  output logic                      slv_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   slv_r_id_o,
  output logic                      slv_r_valid_o,
  input  logic                      slv_r_ready_i
);

  localparam int unsigned SHIFT = $clog2(AXI_STRB_WIDTH);
  localparam int unsigned IW    = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE = AXI_ADDR_WIDTH'(ADDR_BASE);
  localparam logic [2:0] SIZE        = 3'(SHIFT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic burst_err(input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [AXI_ADDR_WIDTH-1:0] first, lst;
    first = (addr - BASE) >> SHIFT;
    lst   = first + ((burst == BURST_INCR) ? AXI_ADDR_WIDTH'(len) : '0);
    return (addr < BASE) || (first >= AXI_ADDR_WIDTH'(MEM_WORDS)) || (lst >= AXI_ADDR_WIDTH'(MEM_WORDS)) ||
           (size != SIZE) || (burst != BURST_FIXED && burst != BURST_INCR);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  w_state_t                w_state;
  logic                    aw_ready, w_ready, b_valid;
  logic [1:0]              b_resp;
  logic [AXI_ID_WIDTH-1:0] b_id, wr_id;
  logic [IW-1:0]           wr_idx;
  logic                    wr_single, wr_lock, wr_err, wr_incr;

  r_state_t                r_state;
  logic                    ar_ready, r_valid;
  logic [1:0]              r_resp;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [IW-1:0]           rd_idx;
  logic [7:0]              rd_len, rd_beat;
  logic                    rd_err, rd_incr;

  logic                    resv_valid;
  logic [AXI_ID_WIDTH-1:0] resv_id;
  logic [IW-1:0]           resv_idx;

  logic          aw_err, ar_err, wr_hs, excl_ok, wr_en, resv_set, resv_clr;
  logic [IW-1:0] aw_idx, ar_idx;

  assign aw_err  = burst_err(slv_aw_addr_i, slv_aw_len_i, slv_aw_size_i, slv_aw_burst_i) || (slv_aw_atop_i != '0);
  assign ar_err  = burst_err(slv_ar_addr_i, slv_ar_len_i, slv_ar_size_i, slv_ar_burst_i);
  assign aw_idx  = IW'((slv_aw_addr_i - BASE) >> SHIFT);
  assign ar_idx  = IW'((slv_ar_addr_i - BASE) >> SHIFT);
  assign wr_hs   = w_ready && slv_w_valid_i;
  assign excl_ok = wr_single && resv_valid && (resv_id == wr_id) && (resv_idx == wr_idx);
  // Gated by reset so a beat presented in the reset cycle is dropped with the rest of the burst.
  assign wr_en   = wr_hs && !rst_i && !wr_err && (!wr_lock || excl_ok);
  assign resv_set = ar_ready && slv_ar_valid_i && slv_ar_lock_i && (slv_ar_len_i == '0) && !ar_err;
  assign resv_clr = wr_en && (wr_idx == resv_idx);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (slv_w_strb_i[b]) mem[wr_idx][8*b +: 8] <= slv_w_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_valid <= 1'b0;
      resv_id    <= '0;
      resv_idx   <= '0;
    end else if (resv_clr) begin
      resv_valid <= 1'b0;
    end else if (resv_set) begin
      resv_valid <= 1'b1;
      resv_id    <= slv_ar_id_i;
      resv_idx   <= ar_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      aw_ready  <= 1'b0;
      w_ready   <= 1'b0;
      b_valid   <= 1'b0;
      b_resp    <= '0;
      b_id      <= '0;
      wr_id     <= '0;
      wr_idx    <= '0;
      wr_single <= 1'b0;
      wr_lock   <= 1'b0;
      wr_err    <= 1'b0;
      wr_incr   <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_ready && slv_aw_valid_i) begin
            wr_id     <= slv_aw_id_i;
            wr_idx    <= aw_idx;
            wr_single <= (slv_aw_len_i == '0);
            wr_lock   <= slv_aw_lock_i;
            wr_err    <= aw_err;
            wr_incr   <= (slv_aw_burst_i == BURST_INCR);
            aw_ready  <= 1'b0;
            w_ready   <= 1'b1;
            w_state   <= W_DATA;
          end else begin
            aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wr_hs) begin
            if (wr_incr) wr_idx <= wr_idx + 1'b1;
            if (slv_w_last_i) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_id    <= wr_id;
              b_resp  <= wr_err ? RESP_SLVERR : ((wr_lock && excl_ok) ? RESP_EXOKAY : RESP_OKAY);
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (slv_b_ready_i) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= '0;
      r_id     <= '0;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_err   <= 1'b0;
      rd_incr  <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_ready && slv_ar_valid_i) begin
            r_id     <= slv_ar_id_i;
            rd_idx   <= ar_idx;
            rd_len   <= slv_ar_len_i;
            rd_beat  <= '0;
            rd_err   <= ar_err;
            rd_incr  <= (slv_ar_burst_i == BURST_INCR);
            r_resp   <= ar_err ? RESP_SLVERR : (slv_ar_lock_i ? RESP_EXOKAY : RESP_OKAY);
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= R_DATA;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (slv_r_ready_i) begin
            if (rd_beat == rd_len) begin
              r_valid  <= 1'b0;
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              rd_beat <= rd_beat + 1'b1;
              if (rd_incr) rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign slv_aw_ready_o = aw_ready;
  assign slv_w_ready_o  = w_ready;
  assign slv_b_valid_o  = b_valid;
  assign slv_b_resp_o   = b_resp;
  assign slv_b_id_o     = b_id;
  assign slv_ar_ready_o = ar_ready;
  assign slv_r_valid_o  = r_valid;
  assign slv_r_resp_o   = r_valid ? r_resp : '0;
  assign slv_r_id_o     = r_id;
  assign slv_r_last_o   = r_valid && (rd_beat == rd_len);
  assign slv_r_data_o   = (r_valid && !rd_err) ? mem[rd_idx] : '0;

endmodule

// File: tb/tb_axi_riscv_excl_mem_resp.sv
// Scoreboard bench for axi_riscv_excl_mem_resp: expected B/R beats are queued at issue time
// from a shadow memory and popped by channel monitors on each handshake.
module tb_axi_riscv_excl_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_lock, ar_lock;
  logic [5:0]  aw_atop;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

  axi_riscv_excl_mem_resp #(
    .ADDR_BASE(64'h0), .MEM_WORDS(256), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_addr_i(aw_addr), .slv_aw_len_i(aw_len), .slv_aw_size_i(aw_size), .slv_aw_burst_i(aw_burst),
    .slv_aw_lock_i(aw_lock), .slv_aw_atop_i(aw_atop), .slv_aw_id_i(aw_id),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready),
    .slv_w_data_i(w_data), .slv_w_strb_i(w_strb), .slv_w_last_i(w_last),
    .slv_w_valid_i(w_valid), .slv_w_ready_o(w_ready),
    .slv_b_resp_o(b_resp), .slv_b_id_o(b_id), .slv_b_valid_o(b_valid), .slv_b_ready_i(b_ready),
    .slv_ar_addr_i(ar_addr), .slv_ar_len_i(ar_len), .slv_ar_size_i(ar_size), .slv_ar_burst_i(ar_burst),
    .slv_ar_lock_i(ar_lock), .slv_ar_id_i(ar_id),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready),
    .slv_r_data_o(r_data), .slv_r_resp_o(r_resp), .slv_r_last_o(r_last), .slv_r_id_o(r_id),
    .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready)
  );

  localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  b_exp_t      be;
  r_exp_t      re;
  logic [63:0] model [256];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic        stalled = 1'b0;
  logic [63:0] held_data;
  logic        held_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      if (bq.size() == 0) check_eq("b_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        check_eq("b_id", b_id, be.id);
        check_eq("b_resp", b_resp, be.resp);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && r_valid) begin
      if (stalled) begin
        check_eq("r_stable_data", r_data, held_data);
        check_eq("r_stable_last", r_last, held_last);
      end
      if (r_ready) begin
        stalled = 1'b0;
        if (rq.size() == 0) check_eq("r_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          check_eq("r_data", r_data, re.data);
          check_eq("r_resp", r_resp, re.resp);
          check_eq("r_last", r_last, re.last);
          check_eq("r_id", r_id, re.id);
        end
      end else begin
        stalled   = 1'b1;
        held_data = r_data;
        held_last = r_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic wait_ready(input int ch, input string tag);
    logic hs;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      hs = (ch == 0) ? aw_ready : (ch == 1) ? w_ready : ar_ready;
      @(posedge clk); #1;
      if (hs) return;
    end
    check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic aw_send(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic lock, input logic [5:0] atop, input logic [3:0] id);
    aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    aw_lock = lock; aw_atop = atop; aw_id = id; aw_valid = 1'b1;
    wait_ready(0, "aw");
    aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    wait_ready(1, "w");
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic lock, input logic [5:0] atop,
                          input logic [3:0] id, input logic [63:0] data, input logic [1:0] exp_resp);
    b_exp_t e;
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    aw_send(addr, len, size, burst, lock, atop, id);
    for (int i = 0; i <= int'(len); i++) w_send(data + 64'(i), 8'hFF, i == int'(len));
    @(negedge clk);
    check_eq("b_valid_next_cycle", b_valid, 1);
    for (int n = 0; n < 64 && bq.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (bq.size() != 0) begin
      check_eq("b_timeout", 0, 1);
      bq.delete();
    end
    if ((exp_resp == OKAY && !lock) || exp_resp == EXOKAY)
      for (int i = 0; i <= int'(len); i++)
        model[8'((addr >> 3) + ((burst == INCR) ? 64'(i) : 64'd0))] = data + 64'(i);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic lock, input logic [3:0] id, input logic [1:0] exp_resp, input logic toggle);
    r_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = (exp_resp == SLVERR) ? 64'd0 : model[8'((addr >> 3) + ((burst == INCR) ? 64'(i) : 64'd0))];
      e.resp = exp_resp;
      e.last = (i == int'(len));
      e.id   = id;
      rq.push_back(e);
    end
    ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_lock = lock; ar_id = id;
    ar_valid = 1'b1; r_ready = 1'b1;
    wait_ready(2, "ar");
    ar_valid = 1'b0;
    @(negedge clk);
    check_eq("r_valid_next_cycle", r_valid, 1);
    for (int n = 0; n < 200 && rq.size() != 0; n++) begin
      @(posedge clk); #1;
      if (toggle) r_ready = ~r_ready;
    end
    if (rq.size() != 0) begin
      check_eq("r_timeout", 0, 1);
      rq.delete();
    end
    r_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_lock = 1'b0; aw_atop = '0; aw_id = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_lock = 1'b0; ar_id = '0; ar_valid = 1'b0; r_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {aw_ready, w_ready, ar_ready}, 0);
    check_eq("rst_valid", {b_valid, r_valid}, 0);
    check_eq("rst_other", {b_resp, b_id, r_resp, r_id, r_last}, 0);
    check_eq("rst_r_data", r_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain write / read-back
    do_write(64'h8, 0, 3, INCR, 0, 0, 4'd3, 64'hDEAD_BEEF, OKAY);
    do_read(64'h8, 0, INCR, 0, 4'd3, OKAY, 0);

    // Exclusive pair succeeds, repeat fails
    do_write(64'h10, 0, 3, INCR, 0, 0, 4'd0, 64'h77, OKAY);
    do_read(64'h10, 0, INCR, 1, 4'd2, EXOKAY, 0);
    do_write(64'h10, 0, 3, INCR, 1, 0, 4'd2, 64'h5, EXOKAY);
    do_read(64'h10, 0, INCR, 0, 4'd2, OKAY, 0);
    do_write(64'h10, 0, 3, INCR, 1, 0, 4'd2, 64'h9, OKAY);
    do_read(64'h10, 0, INCR, 0, 4'd2, OKAY, 0);

    // Intervening normal write breaks the reservation
    do_read(64'h10, 0, INCR, 1, 4'd2, EXOKAY, 0);
    do_write(64'h10, 0, 3, INCR, 0, 0, 4'd7, 64'h6, OKAY);
    do_write(64'h10, 0, 3, INCR, 1, 0, 4'd2, 64'h7, OKAY);
    do_read(64'h10, 0, INCR, 0, 4'd2, OKAY, 0);

    // ID mismatch
    do_read(64'h10, 0, INCR, 1, 4'd1, EXOKAY, 0);
    do_write(64'h10, 0, 3, INCR, 1, 0, 4'd4, 64'h8, OKAY);
    do_read(64'h10, 0, INCR, 0, 4'd1, OKAY, 0);

    // INCR burst with back-pressure
    do_write(64'h20, 3, 3, INCR, 0, 0, 4'd6, 64'h100, OKAY);
    do_read(64'h20, 3, INCR, 0, 4'd6, OKAY, 1);
    do_read(64'h20, 1, FIXED, 0, 4'd6, OKAY, 0);

    // Boundaries and illegal bursts
    do_write(64'h7F8, 0, 3, INCR, 0, 0, 4'd9, 64'hAA55, OKAY);
    do_read(64'h7F8, 0, INCR, 0, 4'd9, OKAY, 0);
    do_read(64'h7F8, 1, INCR, 0, 4'd9, SLVERR, 0);
    do_read(64'h800, 1, INCR, 0, 4'd8, SLVERR, 0);
    do_read(64'h8, 0, WRAP, 1, 4'd8, SLVERR, 0);
    do_write(64'h8, 1, 2, INCR, 0, 0, 4'd10, 64'h1111, SLVERR);
    do_write(64'h8, 0, 3, INCR, 0, 6'h21, 4'd11, 64'h2222, SLVERR);
    do_read(64'h8, 0, INCR, 0, 4'd3, OKAY, 0);

    // Reset in the middle of a write burst
    aw_send(64'h30, 1, 3, INCR, 0, 0, 4'd5);
    w_send(64'h1234, 8'hFF, 0);
    model[6] = 64'h1234;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_ready", {aw_ready, w_ready, ar_ready}, 0);
    check_eq("midrst_valid", {b_valid, r_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_no_b", b_valid, 0);
    @(posedge clk); #1;
    do_read(64'h30, 0, INCR, 0, 4'd5, OKAY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_riscv_excl_mem_resp.md
Name: axi_riscv_excl_mem_resp

Overview:
- AXI4 responder (slave endpoint) with a small register-file memory and a native exclusive-access monitor.
- It sits at the master-side end of the LR/SC filter path. It answers the exclusive (lock) reads and writes that the filter forwards, so the filter can be closed-loop tested and synthesised without external memory.
- One write transaction and one read transaction are in flight at a time; the write and read channels run independently.

Parameters:
- ADDR_BASE, 64'h0, byte address of memory word 0.
- MEM_WORDS, 256, memory depth in words (power of two, ≥2).
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width (32 or 64).
- AXI_ID_WIDTH, 4, ID width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, derived, not overridable.

Ports:
- clk_i in 1 clock
- rst_i in 1 synchronous active-high reset
- slv_aw_addr_i in AXI_ADDR_WIDTH write address
- slv_aw_len_i in 8 beats-1
- slv_aw_size_i in 3 beat size
- slv_aw_burst_i in 2 burst type
- slv_aw_lock_i in 1 exclusive
- slv_aw_atop_i in 6 atomic op
- slv_aw_id_i in AXI_ID_WIDTH ID
- slv_aw_valid_i in 1 / slv_aw_ready_o out 1 AW handshake
- slv_w_data_i in AXI_DATA_WIDTH data
- slv_w_strb_i in AXI_STRB_WIDTH byte enables
- slv_w_last_i in 1 last beat
- slv_w_valid_i in 1 / slv_w_ready_o out 1 W handshake
- slv_b_resp_o out 2 response
- slv_b_id_o out AXI_ID_WIDTH ID
- slv_b_valid_o out 1 / slv_b_ready_i in 1 B handshake
- slv_ar_addr_i, slv_ar_len_i, slv_ar_size_i, slv_ar_burst_i, slv_ar_lock_i, slv_ar_id_i: in, same widths and meanings as the AW fields
- slv_ar_valid_i in 1 / slv_ar_ready_o out 1 AR handshake
- slv_r_data_o out AXI_DATA_WIDTH data
- slv_r_resp_o out 2 response
- slv_r_last_o out 1 last beat
- slv_r_id_o out AXI_ID_WIDTH ID
- slv_r_valid_o out 1 / slv_r_ready_i in 1 R handshake

Behaviour:
- Reset: while rst_i=1, every valid and ready output is 0 and every other output is 0. The write FSM goes to W_IDLE, the read FSM to R_IDLE, and the reservation is cleared. Memory contents are not reset.
- Reset mid-burst aborts the burst silently: no B or R is issued, and beats already written remain written.
- Legality is checked at the address handshake, for the whole burst. A burst is an error (SLVERR=2'b10) if any of these holds:
  - any beat falls outside [ADDR_BASE, ADDR_BASE+MEM_WORDS*STRB);
  - size != log2(STRB);
  - burst == WRAP or reserved;
  - atop != 0 (AW only).
- Word index = (addr-ADDR_BASE)>>log2(STRB). The low address bits are ignored. INCR advances by one word per beat; FIXED keeps the same word.
- Write FSM:
  - W_IDLE: aw_ready=1. On the AW handshake, latch id, index, len, lock and error; go to W_DATA.
  - W_DATA: w_ready=1. Each W handshake writes the bytes enabled by strb, unless the burst is an error or a failed exclusive. On the W handshake with last, go to W_RESP.
  - W_RESP: b_valid=1 from the cycle after the last W handshake; hold until b_ready, then go to W_IDLE.
  - The next AW is accepted at the earliest in the cycle after the B handshake.
- Read FSM:
  - R_IDLE: ar_ready=1. On the AR handshake, latch id, index, len, lock and error; go to R_DATA.
  - R_DATA: r_valid=1 starting the cycle after AR. r_data is memory[index], read combinationally; on error it is 0.
  - r_last=1 on beat len. The index advances on each R handshake. After the last handshake, go to R_IDLE.
- Responses:
  - OKAY=2'b00; SLVERR overrides all.
  - Exclusive read of a legal burst: all beats are EXOKAY=2'b01.
- Exclusive monitor: a single reservation {valid, id, word index}.
  - Set by the AR handshake of a legal exclusive read with len=0. This replaces any prior reservation.
  - An exclusive write succeeds only if len=0, the reservation is valid, and both id and index match. On success: write the data, respond EXOKAY, clear the reservation. On failure: no memory update, respond OKAY.
  - Any successful write beat (normal or exclusive) to the reserved index clears the reservation.
  - If a clear and a set occur in the same cycle, the clear wins: the reservation ends invalid.
- W before AW: W is stalled (w_ready=0 in W_IDLE).
- Same-cycle read and write of one word: R carries the pre-write value.
- A W beat after last, or a missing last, is a protocol violation; behaviour is undefined.

Test Plan:
- Reset, then AW addr=ADDR_BASE+8 len=0 id=3 with W data=64'hDEAD_BEEF strb=8'hFF. Expect B id=3 resp=00 one cycle after W. Then AR to the same address: R data=64'hDEAD_BEEF, last=1, resp=00.
- Exclusive AR id=2 addr=0x10, then exclusive AW id=2 addr=0x10 data=5. Expect R resp=01 and B resp=01; memory[2]=5.
- Repeat that exclusive write: B resp=00 and memory[2] unchanged. Exclusive AR id=2, then normal write to 0x10, then exclusive write by id=2: B resp=00.
- Exclusive AR id=1 then exclusive AW id=4 at the same address: B resp=00, no write.
- INCR read len=3 from word 4 with r_ready toggling 1/0: 4 beats of words 4–7, last only on the 4th beat, data held stable while stalled.
- AR at ADDR_BASE+MEM_WORDS*8 len=1: 2 beats, resp=10, data=0. AW with size=2: all W beats accepted, B resp=10, memory unchanged. rst_i asserted mid-write: all valid and ready outputs are 0 the next cycle, and no B is issued.
